// File: rtl/sprite_row_reader.sv
// Fetches one sprite row byte from sprite_rom and streams it out MSB-first,
// each pixel held for SCALE pix_en strobes. Optional horizontal flip via SPRITE_ROW_MIRROR_EN.
module sprite_row_reader #(
  parameter int unsigned SPRITE_COUNT = 6,
  parameter int unsigned ROWS         = 8,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SCALE        = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req,
  input  logic [2:0]       sprite_id,
  input  logic [2:0]       row,
  input  logic             abort,
  output logic             req_ready,
  output logic [7:0]       rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  input  logic             pix_en,
  output logic             pix_valid,
  output logic             pix_on,
  output logic             busy,
`ifdef SPRITE_ROW_MIRROR_EN
  input  logic             mirror,
`endif
  output logic             done
);

  localparam int unsigned RepW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StShift} state_e;

  state_e            state_q, state_d;
  logic [7:0]        rom_addr_q, rom_addr_d;
  logic              blank_q, blank_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [RepW-1:0]   rep_cnt_q, rep_cnt_d;
  logic [ColW-1:0]   col_cnt_q, col_cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              pix_valid_q, pix_valid_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  row_bits;

`ifdef SPRITE_ROW_MIRROR_EN
  logic              mirror_q, mirror_d;
  logic [WIDTH-1:0]  rom_rev;

  always_comb begin
    rom_rev = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      rom_rev[i] = rom_data[int'(WIDTH) - 1 - i];
    end
    row_bits = mirror_q ? rom_rev : rom_data;
  end
`else
  always_comb begin
    row_bits = rom_data;
  end
`endif

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    blank_d    = blank_q;
    shift_d    = shift_q;
    rep_cnt_d  = rep_cnt_q;
    col_cnt_d  = col_cnt_q;
    done_d     = 1'b0;
`ifdef SPRITE_ROW_MIRROR_EN
    mirror_d   = mirror_q;
`endif

    unique case (state_q)
      StIdle: begin
        // abort beats a simultaneous request
        if (req && !abort) begin
          state_d = StFetch;
`ifdef SPRITE_ROW_MIRROR_EN
          mirror_d = mirror;
`endif
          if (32'(sprite_id) < SPRITE_COUNT) begin
            rom_addr_d = 8'(sprite_id) * 8'(ROWS) + 8'(row);
            blank_d    = 1'b0;
          end else begin
            rom_addr_d = '0;
            blank_d    = 1'b1;
          end
        end
      end
      StFetch: begin
        if (abort) begin
          state_d = StIdle;
          shift_d = '0;
        end else begin
          state_d   = StShift;
          shift_d   = blank_q ? '0 : row_bits;
          rep_cnt_d = '0;
          col_cnt_d = '0;
        end
      end
      StShift: begin
        if (abort) begin
          state_d = StIdle;
          shift_d = '0;
        end else if (pix_en) begin
          if (rep_cnt_q == RepW'(SCALE - 1)) begin
            rep_cnt_d = '0;
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            col_cnt_d = col_cnt_q + ColW'(1);
            if (col_cnt_q == ColW'(WIDTH - 1)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            rep_cnt_d = rep_cnt_q + RepW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    pix_valid_d = (state_d == StShift);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      rom_addr_q  <= '0;
      blank_q     <= 1'b0;
      shift_q     <= '0;
      rep_cnt_q   <= '0;
      col_cnt_q   <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SPRITE_ROW_MIRROR_EN
      mirror_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      blank_q     <= blank_d;
      shift_q     <= shift_d;
      rep_cnt_q   <= rep_cnt_d;
      col_cnt_q   <= col_cnt_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      pix_valid_q <= pix_valid_d;
      done_q      <= done_d;
`ifdef SPRITE_ROW_MIRROR_EN
      mirror_q    <= mirror_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rom_addr  = rom_addr_q;
  assign pix_valid = pix_valid_q;
  assign pix_on    = shift_q[WIDTH-1];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sprite_row_reader.sv
// Randomized self-checking bench for sprite_row_reader; the reference model expands
// each ROM byte into its per-strobe pixel list. Honors SPRITE_ROW_MIRROR_EN.
module tb_sprite_row_reader;

  localparam int SPRITE_COUNT = 6;
  localparam int ROWS         = 8;
  localparam int WIDTH        = 8;
  localparam int SCALE        = 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       req, abort, pix_en;
  logic [2:0] sprite_id, row;
  logic       req_ready, pix_valid, pix_on, busy, done;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       mirror;
  logic [7:0] rom [256];

  int tests  = 0;
  int failed = 0;

  assign rom_data = rom[rom_addr];

  sprite_row_reader dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .sprite_id (sprite_id),
    .row       (row),
    .abort     (abort),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix_en    (pix_en),
    .pix_valid (pix_valid),
    .pix_on    (pix_on),
    .busy      (busy),
`ifdef SPRITE_ROW_MIRROR_EN
    .mirror    (mirror),
`endif
    .done      (done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int exp_addr(input int id, input int r);
    return (id < SPRITE_COUNT) ? id * ROWS + r : 0;
  endfunction

  // Model: row byte (0 if blank, reversed if mirrored), each bit MSB-first repeated SCALE times.
  function automatic void build_expect(input int id, input int r, input bit mir,
                                       output bit px [WIDTH*SCALE]);
    logic [7:0] b;
    b = (id < SPRITE_COUNT) ? rom[id * ROWS + r] : 8'h00;
    for (int p = 0; p < WIDTH; p++) begin
      for (int s = 0; s < SCALE; s++) begin
        px[p*SCALE + s] = mir ? b[p] : b[WIDTH-1-p];
      end
    end
  endfunction

  // Runs one row. pre=1: request already accepted at the last edge.
  // chain=1: issue the next request in the done cycle. poke=1: spam req while busy.
  task automatic run_row(input int id, input int r, input bit mir, input bit pre,
                         input int pen_pct, input bit poke, input bit chain,
                         input int nid, input int nr, input bit nmir);
    bit px [WIDTH*SCALE];
    int strobes, budget;
    int ea;
    build_expect(id, r, mir, px);
    ea = exp_addr(id, r);
    if (!pre) begin
      req = 1'b1; sprite_id = 3'(id); row = 3'(r); mirror = mir;
      tick();
    end
    req = 1'b0;
    tests++;
    if (rom_addr !== 8'(ea) || busy !== 1'b1 || req_ready !== 1'b0 || pix_valid !== 1'b0 ||
        done !== 1'b0) begin
      failed++;
      $display("FAIL fetch id=%0d row=%0d: addr=%0d busy=%b rdy=%b vld=%b done=%b, want addr=%0d 1 0 0 0",
               id, r, rom_addr, busy, req_ready, pix_valid, done, ea);
    end
    pix_en = 1'($urandom_range(0, 1));
    tick();
    strobes = 0;
    budget  = 400;
    while (strobes < WIDTH*SCALE && budget > 0) begin
      budget--;
      pix_en = ($urandom_range(0, 99) < pen_pct);
      if (poke) begin
        req = 1'($urandom_range(0, 1)); sprite_id = 3'($urandom); row = 3'($urandom);
      end
      tests++;
      if (pix_valid !== 1'b1 || done !== 1'b0 || rom_addr !== 8'(ea) || busy !== 1'b1) begin
        failed++;
        $display("FAIL shift_state strobe=%0d: vld=%b done=%b addr=%0d busy=%b, want 1 0 %0d 1",
                 strobes, pix_valid, done, rom_addr, busy, ea);
      end
      if (pix_en) begin
        tests++;
        if (pix_on !== px[strobes]) begin
          failed++;
          $display("FAIL pix_on id=%0d row=%0d strobe=%0d: got %b want %b",
                   id, r, strobes, pix_on, px[strobes]);
        end
        strobes++;
      end
      tick();
    end
    req = 1'b0; pix_en = 1'b0;
    if (budget == 0) begin
      tests++; failed++;
      $display("FAIL row_timeout id=%0d row=%0d: strobes=%0d want %0d", id, r, strobes, WIDTH*SCALE);
    end
    tests++;
    if (done !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0 || pix_valid !== 1'b0) begin
      failed++;
      $display("FAIL done_cycle id=%0d: done=%b rdy=%b busy=%b vld=%b, want 1 1 0 0",
               id, done, req_ready, busy, pix_valid);
    end
    if (chain) begin
      req = 1'b1; sprite_id = 3'(nid); row = 3'(nr); mirror = nmir;
      tick();
    end else begin
      tick();
      tests++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
        failed++;
        $display("FAIL done_pulse_width: done=%b rdy=%b, want 0 1", done, req_ready);
      end
    end
  endtask

  task automatic test_reset();
    tests++;
    if (req_ready !== 1'b1 || rom_addr !== 8'd0 || pix_valid !== 1'b0 || pix_on !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL reset_values: rdy=%b addr=%0d vld=%b on=%b busy=%b done=%b",
               req_ready, rom_addr, pix_valid, pix_on, busy, done);
    end
    req = 1'b1; sprite_id = 3'd1; row = 3'd3; mirror = 1'b0;
    tick();
    req = 1'b0; pix_en = 1'b1;
    tick();
    tick(); tick(); tick();
    tests++;
    if (pix_valid !== 1'b1) begin
      failed++;
      $display("FAIL reset_pre_shift: vld=%b want 1", pix_valid);
    end
    Reset = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b1 || rom_addr !== 8'd0 || pix_valid !== 1'b0 || pix_on !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_shift: rdy=%b addr=%0d vld=%b on=%b busy=%b done=%b",
               req_ready, rom_addr, pix_valid, pix_on, busy, done);
    end
    pix_en = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    tests++;
    if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_release: done=%b rdy=%b busy=%b, want 0 1 0", done, req_ready, busy);
    end
  endtask

  task automatic test_full_row();
    run_row(1, 3, 1'b0, 1'b0, 100, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_pattern();
    run_row(0, 0, 1'b0, 1'b0, 100, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_blank();
    run_row(6, 0, 1'b0, 1'b0, 100, 1'b0, 1'b0, 0, 0, 1'b0);
    run_row(7, 5, 1'b0, 1'b0, 70, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_random_rows();
    for (int k = 0; k < 12; k++) begin
      run_row(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0, 1'b0,
              int'($urandom_range(30, 100)), 1'b0, 1'b0, 0, 0, 1'b0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] a0;
    req = 1'b1; sprite_id = 3'd2; row = 3'd4; tick();
    req = 1'b0; pix_en = 1'b1; tick();
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1; pix_en = 1'b0; tick();
    abort = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || pix_valid !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL abort_shift: rdy=%b busy=%b vld=%b done=%b, want 1 0 0 0",
               req_ready, busy, pix_valid, done);
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      failed++;
      $display("FAIL abort_no_done: done=%b want 0", done);
    end
    req = 1'b1; sprite_id = 3'd4; row = 3'd1; tick();
    req = 1'b0; abort = 1'b1; tick();
    abort = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL abort_fetch: rdy=%b busy=%b done=%b, want 1 0 0", req_ready, busy, done);
    end
    a0 = rom_addr;
    req = 1'b1; abort = 1'b1; sprite_id = 3'd5; row = 3'd7; tick();
    req = 1'b0; abort = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rom_addr !== a0) begin
      failed++;
      $display("FAIL abort_wins_idle: rdy=%b busy=%b addr=%0d, want 1 0 %0d",
               req_ready, busy, rom_addr, a0);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    run_row(3, 6, 1'b0, 1'b0, 100, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_busy_req();
    run_row(5, 2, 1'b0, 1'b0, 60, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_row(2, 1, 1'b0, 1'b0, 100, 1'b0, 1'b1, 4, 7, 1'b0);
    run_row(4, 7, 1'b0, 1'b1, 80, 1'b0, 1'b1, 6, 2, 1'b0);
    run_row(6, 2, 1'b0, 1'b1, 100, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

`ifdef SPRITE_ROW_MIRROR_EN
  task automatic test_mirror();
    run_row(3, 3, 1'b1, 1'b0, 100, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_row(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)), 1'($urandom), 1'b0,
              int'($urandom_range(40, 100)), 1'b0, 1'b0, 0, 0, 1'b0);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0]  = 8'h1C;
    rom[11] = 8'hFF;
    rom[27] = 8'h56;
    Reset = 1'b1; req = 1'b0; abort = 1'b0; pix_en = 1'b0;
    sprite_id = '0; row = '0; mirror = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    test_reset();
    test_full_row();
    test_pattern();
    test_blank();
    test_random_rows();
    test_abort();
    test_busy_req();
    test_back_to_back();
`ifdef SPRITE_ROW_MIRROR_EN
    test_mirror();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
